// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x16 register file with pending scoreboard; REG_FILE_BYPASS_EN enables writeback bypass
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wdata_w,
  input  logic [3:0]  dest_w,
  input  logic        we_w,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  input  logic        use_a,
  input  logic        use_b,
  input  logic        set_en,
  input  logic [3:0]  set_dest,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic        pend_a,
  output logic        pend_b,
  output logic        stall,
  output logic [4:0]  pend_cnt
);

  logic [15:0] regs [16];
  logic [15:0] pend;
  logic [15:0] pend_nxt;
  logic [4:0]  cnt_nxt;

  // Clear from writeback first, then set from issue, so a same-register set wins.
  always_comb begin
    pend_nxt = pend;
    if (we_w)   pend_nxt[dest_w]   = 1'b0;
    if (set_en) pend_nxt[set_dest] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < 16; i++) cnt_nxt = cnt_nxt + {4'd0, pend_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (we_w) regs[dest_w] <= wdata_w;
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic hit_a;
  logic hit_b;

  assign hit_a   = we_w && (dest_w == raddr_a);
  assign hit_b   = we_w && (dest_w == raddr_b);
  assign rdata_a = hit_a ? wdata_w : regs[raddr_a];
  assign rdata_b = hit_b ? wdata_w : regs[raddr_b];
  assign pend_a  = pend[raddr_a] & ~hit_a;
  assign pend_b  = pend[raddr_b] & ~hit_b;
`else
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign pend_a  = pend[raddr_a];
  assign pend_b  = pend[raddr_b];
`endif

  assign stall = (pend_a & use_a) | (pend_b & use_b);

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed bench for reg_file against a behavioural model
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [15:0] wdata_w;
  logic [3:0]  dest_w;
  logic        we_w;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic        use_a;
  logic        use_b;
  logic        set_en;
  logic [3:0]  set_dest;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        pend_a;
  logic        pend_b;
  logic        stall;
  logic [4:0]  pend_cnt;

  reg_file dut (
    .clk(clk), .rst(rst), .wdata_w(wdata_w), .dest_w(dest_w), .we_w(we_w),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .use_a(use_a), .use_b(use_b),
    .set_en(set_en), .set_dest(set_dest), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .pend_a(pend_a), .pend_b(pend_b), .stall(stall), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_regs [16];
  bit          m_pend [16];
  bit          m_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned exp_rd(input int unsigned addr);
`ifdef REG_FILE_BYPASS_EN
    if (we_w && dest_w == addr) return wdata_w;
`endif
    return m_regs[addr];
  endfunction

  function automatic bit exp_pd(input int unsigned addr);
`ifdef REG_FILE_BYPASS_EN
    if (we_w && dest_w == addr) return 1'b0;
`endif
    return m_pend[addr];
  endfunction

  function automatic int unsigned model_cnt();
    int unsigned n = 0;
    for (int i = 0; i < 16; i++) n += m_pend[i];
    return n;
  endfunction

  // Inputs are driven just after an edge; combinational outputs are checked mid-cycle,
  // the model advances at the edge and the registered count is checked 1 time unit later.
  task automatic tick();
    bit pa;
    bit pb;
    #2;
    if (m_valid) begin
      pa = exp_pd(raddr_a);
      pb = exp_pd(raddr_b);
      check("rdata_a", rdata_a, exp_rd(raddr_a));
      check("rdata_b", rdata_b, exp_rd(raddr_b));
      check("pend_a", pend_a, pa);
      check("pend_b", pend_b, pb);
      check("stall", stall, (pa && use_a) || (pb && use_b));
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = 0;
        m_pend[i] = 0;
      end
      m_valid = 1;
    end else begin
      if (we_w) begin
        m_regs[dest_w] = wdata_w;
        m_pend[dest_w] = 0;
      end
      if (set_en) m_pend[set_dest] = 1;
    end
    #1;
    if (m_valid) check("pend_cnt", pend_cnt, model_cnt());
  endtask

  task automatic idle();
    we_w = 0; set_en = 0; use_a = 0; use_b = 0;
  endtask

  initial begin
    rst = 0; we_w = 1; dest_w = 3; wdata_w = 16'hBEEF;
    raddr_a = 3; raddr_b = 3; use_a = 1; use_b = 1; set_en = 1; set_dest = 3;
    tick(); tick();
    rst = 1; idle();
    tick();
    check("reset_r3", rdata_a, 0);
    check("reset_cnt", pend_cnt, 0);

    we_w = 1; dest_w = 5; wdata_w = 16'h1234; raddr_a = 5; raddr_b = 5;
    tick();
    idle();
    #1 check("write_r5", rdata_b, 16'h1234);
    tick();

    set_en = 1; set_dest = 7;
    tick();
    idle(); raddr_a = 7; use_a = 1;
    tick();
    check("set_r7_cnt", pend_cnt, 1);
    we_w = 1; dest_w = 7; wdata_w = 16'h00AA;
    tick();
    we_w = 0;
    tick();
    check("clear_r7", pend_a, 0);

    idle(); set_en = 1; set_dest = 2;
    tick();
    we_w = 1; dest_w = 2; wdata_w = 16'h5A5A; set_en = 1; set_dest = 2; raddr_a = 2;
    tick();
    idle();
    #1 check("same_reg_pend", pend_a, 1);
    check("same_reg_data", rdata_a, 16'h5A5A);
    tick();

    for (int i = 0; i < 16; i++) begin
      idle(); set_en = 1; set_dest = 4'(i); raddr_a = 4'(i); raddr_b = 4'(15 - i);
      tick();
    end
    check("fill_cnt", pend_cnt, 16);
    for (int i = 0; i < 16; i++) begin
      idle(); we_w = 1; dest_w = 4'(i); wdata_w = 16'(i * 16'h0101);
      raddr_a = 4'(i); use_a = 1;
      tick();
    end
    check("drain_cnt", pend_cnt, 0);

    idle(); set_en = 1; set_dest = 9;
    tick();
    idle(); raddr_b = 9; use_b = 0;
    tick();
    use_b = 1;
    tick();

    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) != 0);
      we_w     = $urandom_range(0, 1);
      dest_w   = 4'($urandom_range(0, 15));
      wdata_w  = 16'($urandom);
      set_en   = $urandom_range(0, 1);
      set_dest = 4'($urandom_range(0, 15));
      raddr_a  = ($urandom_range(0, 3) == 0) ? dest_w : 4'($urandom_range(0, 15));
      raddr_b  = ($urandom_range(0, 3) == 0) ? dest_w : 4'($urandom_range(0, 15));
      use_a    = $urandom_range(0, 1);
      use_b    = $urandom_range(0, 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the basic processor: 16 registers × 16 bits, with two combinational read ports and one write port. The write port is driven directly by the writeback stage outputs (`wdata_w`, `dest_w`, `we_w`), so this block is the consumer end of the writeback interface. A per-register pending scoreboard is set by the decode/issue logic and cleared by writeback. Decode uses the resulting stall signal to hold an instruction whose sources are still in flight.

## Interface
Parameters: none; widths are fixed at 16-bit data and 4-bit register address.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, synchronous, active-low.
- `wdata_w`  in  16  — writeback data.
- `dest_w`  in  4  — writeback destination register.
- `we_w`  in  1  — writeback write enable.
- `raddr_a`  in  4  — read port A address.
- `raddr_b`  in  4  — read port B address.
- `use_a`  in  1  — decode actually consumes source A this cycle.
- `use_b`  in  1  — decode actually consumes source B this cycle.
- `set_en`  in  1  — issue marks `set_dest` as pending.
- `set_dest`  in  4  — destination register of the issuing instruction.
- `rdata_a`  out  16  — read data, port A.
- `rdata_b`  out  16  — read data, port B.
- `pend_a`  out  1  — source A register is pending.
- `pend_b`  out  1  — source B register is pending.
- `stall`  out  1  — hold decode; equals `(pend_a & use_a) | (pend_b & use_b)`.
- `pend_cnt`  out  5  — number of pending registers, range 0..16.

## Operation
- **Storage:** `regs[0..15]`, 16 bits each. Writes are synchronous: on a rising edge with `rst=1` and `we_w=1`, `regs[dest_w] <= wdata_w`. Every register, including r0, is writable.
- **Reads:** `rdata_a = regs[raddr_a]` and `rdata_b = regs[raddr_b]`, combinational. Bypass behaviour is defined under Configuration.
- **Scoreboard:** `pend[0..15]`, 1 bit each. On each edge with `rst=1`:
  - If `we_w=1`, `pend[dest_w]` clears.
  - Then, if `set_en=1`, `pend[set_dest]` sets.
  - When both target the same register, set wins and the bit ends at 1.
  - Setting an already pending register leaves it at 1 (no nesting or depth tracking).
  - A write to a non-pending register updates data and leaves the scoreboard unchanged.
- **`pend_cnt`:** registered. After every edge it equals the population count of `pend`.
  - Set of a non-pending register plus clear of a different pending register in the same cycle: count unchanged.
  - Set and clear of the same register that was pending: count unchanged.
  - Set and clear of the same register that was not pending: count +1.
- **`pend_a` / `pend_b`:** equal `pend[raddr_a]` / `pend[raddr_b]`, subject to the bypass rules under Configuration.
- **`stall`:** purely combinational from `pend_a`, `pend_b`, `use_a`, `use_b`. It does not gate `set_en`; decode must not assert `set_en` while `stall=1`.

## Timing
- **Reset:** when `rst=0` at an edge, all `regs` become 0x0000, all `pend` bits become 0, and `pend_cnt` becomes 0.
  - Concurrent `we_w` and `set_en` are ignored.
  - Resulting output values: `rdata_a=rdata_b=0x0000`, `pend_a=pend_b=stall=0`, `pend_cnt=0`.
  - Reset asserted mid-operation discards every in-flight pending mark.
- **Write latency:** one edge. Data written at edge N is visible on the read ports immediately after edge N.
- **Scoreboard latency:** a `set_en` at edge N raises `pend_a`/`pend_b` after edge N. A clearing writeback at edge N drops them after edge N, or in the same cycle when bypass is enabled.
- **Read-during-write:** same-cycle result is defined under Configuration.

## Configuration
`REG_FILE_BYPASS_EN`:
- **Defined:**
  - When `we_w=1` and `dest_w==raddr_a`, `rdata_a=wdata_w` and `pend_a=0` in that cycle. Port B behaves the same way.
  - Consequence: a dependent instruction proceeds in the cycle its producer writes back.
- **Undefined:**
  - Reads return the stored (old) value, and `pend_*` reflects the stored scoreboard bit.
  - Consequence: the consumer stalls one extra cycle and reads the new value after the edge.

## Test plan
1. **Reset with concurrent write:** hold `rst=0` for 2 cycles with `we_w=1`, `dest_w=3`, `wdata_w=0xBEEF` → after release, `regs[3]` reads 0x0000, `pend_cnt=0`, `stall=0`.
2. **Basic write/read:** write 0x1234 to r5, then read with `raddr_a=5`, `raddr_b=5` → both ports return 0x1234 one cycle after the write edge.
3. **Set then clear:** `set_en=1`, `set_dest=7`; next cycle `raddr_a=7`, `use_a=1` → `pend_a=1`, `stall=1`, `pend_cnt=1`. Then writeback r7=0x00AA → with bypass, same cycle `rdata_a=0x00AA`, `stall=0`; without bypass, `stall` clears one cycle later. After the edge, `pend_cnt=0`.
4. **Set and clear of same register in one cycle:** with r2 pending, `we_w=1`, `dest_w=2`, `set_en=1`, `set_dest=2` → `pend[2]` stays 1, `regs[2]` updated, `pend_cnt` unchanged.
5. **Fill all registers:** set all 16 registers on consecutive cycles → `pend_cnt` counts 1..16 and saturates naturally at 16. Then write back r0..r15 → count decrements to 0.
6. **Stall masking:** `pend_b=1` with `use_b=0` → `stall=0`. Raise `use_b=1` → `stall=1` in the same cycle.
